melody_pwm_player: RTL and testbench



---
 rtl/melody_pwm_player.sv | 210 +++++++++++++++++++++
 tb/tb_melody_pwm_player.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_pwm_player.sv
// melody_pwm_player: steps through a 16-entry song ROM (Ode to Joy phrase) and
// plays each note as a 50% duty square wave on aud_pwm. Every note is followed
// by a short silent gap. aud_sd turns the amplifier on while a song is playing.
module melody_pwm_player #(
   parameter int unsigned CLK_HZ      = 25_175_000,
   parameter int unsigned BEAT_CYCLES = 6_293_750,
   parameter int unsigned GAP_CYCLES  = 251_750,
   parameter bit          LOOP        = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       aud_pwm,
   output logic       aud_sd,
   output logic [3:0] note_idx,
   output logic       note_start
);

   localparam int unsigned IdxW    = 4;
   localparam int unsigned DurW    = 32;
   localparam int unsigned HpW     = 16;
   localparam int unsigned CodeW   = 4;
   localparam int unsigned LenW    = 2;
   localparam int unsigned LastIdx = 15;

   // The pitch table is precomputed for CLK_HZ; zero-length timing is meaningless.
   if (CLK_HZ == 0 || BEAT_CYCLES == 0 || GAP_CYCLES == 0) begin : g_param_check
      $error("melody_pwm_player: CLK_HZ, BEAT_CYCLES and GAP_CYCLES must be nonzero");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Song ROM, pitch half of each {code, len} entry.
   function automatic logic [CodeW-1:0] rom_code(input logic [IdxW-1:0] idx);
      logic [CodeW-1:0] code;
      case (idx)
         4'd0, 4'd1, 4'd6, 4'd11, 4'd12: code = 4'd3;  // E4
         4'd2, 4'd5:                     code = 4'd4;  // F4
         4'd3, 4'd4:                     code = 4'd5;  // G4
         4'd7, 4'd10, 4'd13, 4'd14:      code = 4'd2;  // D4
         4'd8, 4'd9:                     code = 4'd1;  // C4
         default:                        code = 4'd0;  // rest
      endcase
      return code;
   endfunction

   // Song ROM, length half of each {code, len} entry (beats - 1).
   function automatic logic [LenW-1:0] rom_len(input logic [IdxW-1:0] idx);
      logic [LenW-1:0] len;
      case (idx)
         4'd12, 4'd14, 4'd15: len = 2'd1;
         default:             len = 2'd0;
      endcase
      return len;
   endfunction

   // Half period in clocks for each pitch code; zero marks a rest.
   function automatic logic [HpW-1:0] half_period(input logic [CodeW-1:0] code);
      logic [HpW-1:0] hp;
      case (code)
         4'd1:    hp = 16'd48112;
         4'd2:    hp = 16'd42864;
         4'd3:    hp = 16'd38187;
         4'd4:    hp = 16'd36044;
         4'd5:    hp = 16'd32111;
         4'd6:    hp = 16'd28608;
         4'd7:    hp = 16'd25487;
         4'd8:    hp = 16'd24056;
         default: hp = 16'd0;
      endcase
      return hp;
   endfunction

   // Total TONE length in clocks for an entry of the given length field.
   function automatic logic [DurW-1:0] tone_cycles(input logic [LenW-1:0] len);
      return (DurW'(len) + DurW'(1)) * DurW'(BEAT_CYCLES);
   endfunction

   state_e          state_q, state_d;
   logic [DurW-1:0] dur_q, dur_d;     // TONE clocks remaining after this one
   logic [DurW-1:0] gap_q, gap_d;     // GAP clocks remaining after this one
   logic [HpW-1:0]  hp_q, hp_d;       // clocks since the last pwm toggle
   logic [IdxW-1:0] idx_q, idx_d;
   logic            pwm_q, pwm_d;
   logic            sd_q, sd_d;
   logic            start_q, start_d;

   logic [HpW-1:0]  cur_hp_c;
   logic            load_c;
   logic [IdxW-1:0] load_idx_c;

   assign cur_hp_c = half_period(rom_code(idx_q));

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dur_q   <= '0;
         gap_q   <= '0;
         hp_q    <= '0;
         idx_q   <= '0;
         pwm_q   <= 1'b0;
         sd_q    <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         hp_q    <= hp_d;
         idx_q   <= idx_d;
         pwm_q   <= pwm_d;
         sd_q    <= sd_d;
         start_q <= start_d;
      end
   end

   // Next-state logic: disable wins over any expiry; entering TONE loads a fresh entry.
   always_comb begin
      state_d    = state_q;
      dur_d      = dur_q;
      gap_d      = gap_q;
      hp_d       = hp_q;
      idx_d      = idx_q;
      pwm_d      = pwm_q;
      sd_d       = sd_q;
      start_d    = 1'b0;
      load_c     = 1'b0;
      load_idx_c = idx_q;

      if (!en) begin
         state_d = ST_IDLE;
         dur_d   = '0;
         gap_d   = '0;
         hp_d    = '0;
         idx_d   = '0;
         pwm_d   = 1'b0;
         sd_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               load_c     = 1'b1;
               load_idx_c = '0;
            end
            ST_TONE: begin
               if (dur_q == '0) begin
                  state_d = ST_GAP;
                  gap_d   = DurW'(GAP_CYCLES - 1);
                  hp_d    = '0;
                  pwm_d   = 1'b0;
               end else begin
                  dur_d = dur_q - DurW'(1);
                  if (cur_hp_c != '0) begin
                     if (hp_q == cur_hp_c - HpW'(1)) begin
                        hp_d  = '0;
                        pwm_d = ~pwm_q;
                     end else begin
                        hp_d = hp_q + HpW'(1);
                     end
                  end
               end
            end
            ST_GAP: begin
               if (gap_q == '0) begin
                  if (idx_q != IdxW'(LastIdx)) begin
                     load_c     = 1'b1;
                     load_idx_c = idx_q + IdxW'(1);
                  end else if (LOOP) begin
                     load_c     = 1'b1;
                     load_idx_c = '0;
                  end else begin
                     state_d = ST_IDLE;
                     idx_d   = '0;
                     pwm_d   = 1'b0;
                     sd_d    = 1'b0;
                  end
               end else begin
                  gap_d = gap_q - DurW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               pwm_d   = 1'b0;
               sd_d    = 1'b0;
            end
         endcase

         if (load_c) begin
            state_d = ST_TONE;
            idx_d   = load_idx_c;
            dur_d   = tone_cycles(rom_len(load_idx_c)) - DurW'(1);
            gap_d   = '0;
            hp_d    = '0;
            pwm_d   = (half_period(rom_code(load_idx_c)) != '0);
            sd_d    = 1'b1;
            start_d = 1'b1;
         end
      end
   end

   assign aud_pwm    = pwm_q;
   assign aud_sd     = sd_q;
   assign note_idx   = idx_q;
   assign note_start = start_q;

endmodule

// File: tb/tb_melody_pwm_player.sv
// Bench for melody_pwm_player: three instances (long beat, short beat looping,
// short beat one-shot) run side by side against a time-in-entry model.
module tb_melody_pwm_player;

   logic       clk;
   logic       rst_v  [3];
   logic       en_v   [3];
   logic       pwm_o  [3];
   logic       sd_o   [3];
   logic       st_o   [3];
   logic [3:0] idx_o  [3];

   int vectors;
   int miscompares;

   // Song as written in the score: pitch code and beat count per entry.
   int          code_tab  [16] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2, 0};
   int          beats_tab [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 2, 2};
   int unsigned hp_tab    [9]  = '{0, 48112, 42864, 38187, 36044, 32111, 28608, 25487, 24056};

   int unsigned beat_c [3] = '{200000, 100, 100};
   int unsigned gap_c  [3] = '{10, 10, 10};
   bit          loop_c [3] = '{1'b1, 1'b1, 1'b0};

   // Model state: playing flag, entry index, cycles since that entry's TONE start.
   bit          m_play [3];
   int          m_idx  [3];
   int unsigned m_t    [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   melody_pwm_player #(.CLK_HZ(25_175_000), .BEAT_CYCLES(200000), .GAP_CYCLES(10), .LOOP(1'b1)) u_dut_a (
      .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .aud_pwm(pwm_o[0]), .aud_sd(sd_o[0]),
      .note_idx(idx_o[0]), .note_start(st_o[0]));

   melody_pwm_player #(.CLK_HZ(25_175_000), .BEAT_CYCLES(100), .GAP_CYCLES(10), .LOOP(1'b1)) u_dut_b (
      .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .aud_pwm(pwm_o[1]), .aud_sd(sd_o[1]),
      .note_idx(idx_o[1]), .note_start(st_o[1]));

   melody_pwm_player #(.CLK_HZ(25_175_000), .BEAT_CYCLES(100), .GAP_CYCLES(10), .LOOP(1'b0)) u_dut_c (
      .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .aud_pwm(pwm_o[2]), .aud_sd(sd_o[2]),
      .note_idx(idx_o[2]), .note_start(st_o[2]));

   // Advance the model one clock using the sampled rst/en.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         bit          np;
         int          ni;
         int unsigned nt;
         np = m_play[d];
         ni = m_idx[d];
         nt = m_t[d];
         if (rst_v[d] || !en_v[d]) begin
            np = 1'b0; ni = 0; nt = 0;
         end else if (!np) begin
            np = 1'b1; ni = 0; nt = 0;
         end else begin
            nt = nt + 1;
            if (nt == int'(beats_tab[ni]) * beat_c[d] + gap_c[d]) begin
               nt = 0;
               if (ni < 15) ni = ni + 1;
               else if (loop_c[d]) ni = 0;
               else begin np = 1'b0; ni = 0; end
            end
         end
         m_play[d] <= np;
         m_idx[d]  <= ni;
         m_t[d]    <= nt;
      end
   end

   // Expected {pwm, sd, idx, start} from the model's position within the song.
   function automatic logic [6:0] expect_out(input int d);
      int unsigned dur, hp, t;
      logic p, s, st;
      if (rst_v[d] || !m_play[d]) return 7'd0;
      t   = m_t[d];
      dur = int'(beats_tab[m_idx[d]]) * beat_c[d];
      hp  = hp_tab[code_tab[m_idx[d]]];
      s   = 1'b1;
      if (t < dur) begin
         st = (t == 0);
         p  = (hp != 0) && (((t / hp) % 2) == 0);
      end else begin
         st = 1'b0;
         p  = 1'b0;
      end
      return {p, s, 4'(m_idx[d]), st};
   endfunction

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         logic [6:0] act, exp_v;
         act   = {pwm_o[d], sd_o[d], idx_o[d], st_o[d]};
         exp_v = expect_out(d);
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL model_dut%0d t=%0t got pwm,sd,idx,start=%b want %b", d, $time, act, exp_v);
         end
      end
   end

   task automatic check(input string nm, input longint act, input longint exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int d, input int want, input int budget, input string nm);
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!(st_o[d] && idx_o[d] == 4'(want)) && n < budget);
      check(nm, (st_o[d] && idx_o[d] == 4'(want)) ? 1 : 0, 1);
   endtask

   // Long-beat instance: E4 waveform shape, then async reset mid-tone.
   task automatic run_a();
      tick($urandom_range(1, 20));
      en_v[0] = 1'b1;
      tick(1);
      check("a_first_start", st_o[0], 1);
      check("a_first_idx", idx_o[0], 0);
      check("a_first_pwm", pwm_o[0], 1);
      check("a_first_sd", sd_o[0], 1);
      tick(38186);
      check("a_pwm_last_high", pwm_o[0], 1);
      tick(1);
      check("a_pwm_first_low", pwm_o[0], 0);
      check("a_sd_in_tone", sd_o[0], 1);
      tick(38186);
      check("a_pwm_last_low", pwm_o[0], 0);
      tick(1);
      check("a_pwm_high_again", pwm_o[0], 1);
      tick($urandom_range(100, 600));
      @(posedge clk);
      #3 rst_v[0] = 1'b1;
      #1;
      check("a_async_rst_sd", sd_o[0], 0);
      check("a_async_rst_pwm", pwm_o[0], 0);
      tick(1);
      rst_v[0] = 1'b0;
      tick(1);
      check("a_resume_start", st_o[0], 1);
      check("a_resume_idx", idx_o[0], 0);
      tick(50);
   endtask

   // Looping instance: note spacing, wrap, disable mid-note and at gap expiry.
   task automatic run_b();
      int exp_sp [16] = '{110, 110, 110, 110, 110, 110, 110, 110, 110, 110, 110, 110, 210, 110, 210, 210};
      int n;
      tick($urandom_range(1, 10));
      en_v[1] = 1'b1;
      tick(1);
      check("b_first_start", st_o[1], 1);
      for (int k = 0; k < 32; k++) begin
         n = 0;
         do begin
            tick(1);
            n++;
         end while (!st_o[1] && n < 400);
         check("b_spacing", n, exp_sp[k % 16]);
         check("b_next_idx", idx_o[1], (k + 1) % 16);
      end
      wait_start(1, 5, 1000, "b_reach_entry5");
      tick($urandom_range(0, 98));
      en_v[1] = 1'b0;
      tick(1);
      check("b_dis_pwm", pwm_o[1], 0);
      check("b_dis_sd", sd_o[1], 0);
      check("b_dis_idx", idx_o[1], 0);
      tick($urandom_range(1, 5));
      en_v[1] = 1'b1;
      tick(1);
      check("b_reen_start", st_o[1], 1);
      check("b_reen_idx", idx_o[1], 0);
      wait_start(1, 3, 1000, "b_reach_entry3");
      tick(109);
      en_v[1] = 1'b0;
      tick(1);
      check("b_gapexp_idx", idx_o[1], 0);
      check("b_gapexp_sd", sd_o[1], 0);
      check("b_gapexp_start", st_o[1], 0);
      for (int r = 0; r < 20; r++) begin
         tick($urandom_range(1, 5));
         en_v[1] = 1'b1;
         tick($urandom_range(1, 400));
         en_v[1] = 1'b0;
      end
      tick(3);
   endtask

   // One-shot instance: end of song returns to IDLE, then restarts.
   task automatic run_c();
      tick($urandom_range(1, 10));
      en_v[2] = 1'b1;
      wait_start(2, 15, 2500, "c_reach_entry15");
      check("c_rest_pwm", pwm_o[2], 0);
      check("c_rest_sd", sd_o[2], 1);
      tick(209);
      check("c_gap_pwm", pwm_o[2], 0);
      check("c_gap_sd", sd_o[2], 1);
      tick(1);
      check("c_idle_sd", sd_o[2], 0);
      check("c_idle_idx", idx_o[2], 0);
      check("c_idle_start", st_o[2], 0);
      tick(1);
      check("c_restart_start", st_o[2], 1);
      check("c_restart_idx", idx_o[2], 0);
      for (int r = 0; r < 10; r++) begin
         tick($urandom_range(1, 600));
         en_v[2] = 1'b0;
         tick($urandom_range(1, 5));
         en_v[2] = 1'b1;
      end
      tick(2000);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int d = 0; d < 3; d++) begin
         rst_v[d] = 1'b1;
         en_v[d]  = 1'b0;
      end
      tick(3);
      for (int d = 0; d < 3; d++) begin
         check("reset_pwm", pwm_o[d], 0);
         check("reset_sd", sd_o[d], 0);
         check("reset_idx", idx_o[d], 0);
         check("reset_start", st_o[d], 0);
         rst_v[d] = 1'b0;
      end
      fork
         run_a();
         run_b();
         run_c();
      join
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog t=%0t got no finish want finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
